// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, write request type and grant encodings for the register-file write port.
package regfile_pkg;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NUM_REGS = 1 << AW;
  typedef struct packed {
    logic [AW-1:0] da;
    logic [DW-1:0] data;
  } wb_req_t;
  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_WB   = 2'd1;
  localparam logic [1:0] GNT_LU   = 2'd2;
endpackage

// File: rtl/wb_result_fifo.sv
// wb_result_fifo: synchronous FIFO buffering long-latency results until they win the write port.
module wb_result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [PW:0]   r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + 1'b1;
      if (i_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (PW+1)'(i_push) - (PW+1)'(i_pop);
    end
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wp] <= i_din;
  assign o_dout  = r_mem[r_rp];
  assign o_full  = r_cnt == (PW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
endmodule

// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: shares the register-file write port between writeback and buffered
// long-latency results, with a starvation guard and a pending-destination scoreboard.
module regfile_wb_sched
  import regfile_pkg::*;
#(
  parameter int DW         = regfile_pkg::DW,
  parameter int AW         = regfile_pkg::AW,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wb_valid,
  input  logic [AW-1:0] i_wb_da,
  input  logic [DW-1:0] i_wb_data,
  output logic          o_wb_hold,
  input  logic          i_lu_valid,
  output logic          o_lu_ready,
  input  logic [AW-1:0] i_lu_da,
  input  logic [DW-1:0] i_lu_data,
  input  logic          i_iss_valid,
  input  logic          i_iss_long,
  input  logic [AW-1:0] i_iss_da,
  input  logic [AW-1:0] i_chk_aa,
  input  logic [AW-1:0] i_chk_ba,
  output logic          o_issue_stall,
  output logic          o_rf_rw,
  output logic [AW-1:0] o_rf_da,
  output logic [DW-1:0] o_rf_wdata
);
  localparam int NR = 1 << AW;
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [AW+DW-1:0] w_head;
  logic [AW-1:0]    w_lu_da;
  logic [DW-1:0]    w_lu_data;
  logic             w_full, w_empty, w_push, w_pop, w_preempt, w_set;
  logic [1:0]       w_gnt;
  logic [SW-1:0]    r_starve;
  logic [NR-1:0]    r_pend, w_pend_nxt;
  logic             r_rw;
  logic [AW-1:0]    r_da;
  logic [DW-1:0]    r_wdata;
  wb_result_fifo #(.DEPTH(FIFO_DEPTH), .W(AW+DW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   ({i_lu_da, i_lu_data}),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  assign {w_lu_da, w_lu_data} = w_head;
  assign o_lu_ready = !w_full;
  assign w_push     = i_lu_valid && !w_full;
  assign w_preempt  = !w_empty && r_starve == SW'(STARVE_MAX);
  assign w_gnt = w_preempt ? GNT_LU :
                 (i_wb_valid && i_wb_da != '0) ? GNT_WB :
                 !w_empty ? GNT_LU : GNT_NONE;
  assign w_pop     = w_gnt == GNT_LU;
  assign o_wb_hold = w_preempt;
  assign o_issue_stall = r_pend[i_chk_aa] | r_pend[i_chk_ba] | r_pend[i_iss_da];
  assign w_set = i_iss_valid && i_iss_long && i_iss_da != '0 && !o_issue_stall;
  // set is applied after clear so a same-address issue keeps the register pending
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_pop) w_pend_nxt[w_lu_da] = 1'b0;
    if (w_set) w_pend_nxt[i_iss_da] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_starve <= '0;
      r_pend   <= '0;
      r_rw     <= 1'b0;
      r_da     <= '0;
      r_wdata  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_empty || w_pop) r_starve <= '0;
      else if (w_gnt == GNT_WB && r_starve != SW'(STARVE_MAX)) r_starve <= r_starve + 1'b1;
      r_rw <= (w_gnt == GNT_WB) || (w_pop && w_lu_da != '0);
      if (w_gnt != GNT_NONE) begin
        r_da    <= (w_gnt == GNT_WB) ? i_wb_da : w_lu_da;
        r_wdata <= (w_gnt == GNT_WB) ? i_wb_data : w_lu_data;
      end
    end
  assign o_rf_rw    = r_rw;
  assign o_rf_da    = r_da;
  assign o_rf_wdata = r_wdata;
endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb_regfile_wb_sched: directed vectors with hand-computed expectations for the write-port scheduler.
module tb_regfile_wb_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0, lu_valid = 1'b0, iss_valid = 1'b0, iss_long = 1'b0;
  logic [4:0]  wb_da = '0, lu_da = '0, iss_da = '0, chk_aa = '0, chk_ba = '0;
  logic [31:0] wb_data = '0, lu_data = '0;
  logic        wb_hold, lu_ready, issue_stall, rf_rw;
  logic [4:0]  rf_da;
  logic [31:0] rf_wdata;
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  regfile_wb_sched dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_wb_valid    (wb_valid),
    .i_wb_da       (wb_da),
    .i_wb_data     (wb_data),
    .o_wb_hold     (wb_hold),
    .i_lu_valid    (lu_valid),
    .o_lu_ready    (lu_ready),
    .i_lu_da       (lu_da),
    .i_lu_data     (lu_data),
    .i_iss_valid   (iss_valid),
    .i_iss_long    (iss_long),
    .i_iss_da      (iss_da),
    .i_chk_aa      (chk_aa),
    .i_chk_ba      (chk_ba),
    .o_issue_stall (issue_stall),
    .o_rf_rw       (rf_rw),
    .o_rf_da       (rf_da),
    .o_rf_wdata    (rf_wdata)
  );
  // same-destination requests from both sources break the hazard contract
  always @(posedge clk)
    assert (!(rst_n && wb_valid && lu_valid && wb_da != 0 && wb_da == lu_da))
      else $error("FAIL proto same-da wb/lu da=%0d", wb_da);
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_rf(input string tag, input logic rw, input logic [4:0] da, input logic [31:0] d);
    chk({tag, ".rw"}, 64'(rf_rw), 64'(rw));
    if (rw) begin
      chk({tag, ".da"}, 64'(rf_da), 64'(da));
      chk({tag, ".data"}, 64'(rf_wdata), 64'(d));
    end
  endtask
  initial begin
    cyc();
    cyc();
    chk("rst.rw", 64'(rf_rw), 0);
    chk("rst.da", 64'(rf_da), 0);
    chk("rst.wdata", 64'(rf_wdata), 0);
    chk("rst.ready", 64'(lu_ready), 1);
    chk("rst.hold", 64'(wb_hold), 0);
    chk("rst.stall", 64'(issue_stall), 0);
    rst_n = 1'b1;
    cyc();
    // writeback only
    wb_valid = 1; wb_da = 5; wb_data = 32'hDEAD;
    cyc();
    chk_rf("wb5", 1, 5, 32'hDEAD);
    wb_da = 0;
    cyc();
    chk_rf("wb0", 0, 0, 0);
    wb_valid = 0;
    // scoreboard set/clear through a long-latency result
    iss_valid = 1; iss_long = 1; iss_da = 7;
    #1 chk("sb.pre", 64'(issue_stall), 0);
    cyc();
    iss_valid = 0; iss_long = 0; iss_da = 0; chk_aa = 7;
    #1 chk("sb.aa", 64'(issue_stall), 1);
    chk_aa = 0; chk_ba = 7;
    #1 chk("sb.ba", 64'(issue_stall), 1);
    chk_ba = 0; iss_da = 7;
    #1 chk("sb.iss", 64'(issue_stall), 1);
    iss_da = 0; chk_aa = 6;
    #1 chk("sb.other", 64'(issue_stall), 0);
    chk_aa = 7;
    lu_valid = 1; lu_da = 7; lu_data = 32'h11;
    cyc();
    lu_valid = 0;
    chk("sb.queued", 64'(issue_stall), 1);
    cyc();
    chk_rf("sb.write", 1, 7, 32'h11);
    chk("sb.cleared", 64'(issue_stall), 0);
    chk_aa = 0;
    // discard of a da=0 result
    lu_valid = 1; lu_da = 0; lu_data = 32'h55;
    cyc();
    lu_valid = 0;
    chk("disc.idle", 64'(rf_rw), 0);
    cyc();
    chk("disc.rw", 64'(rf_rw), 0);
    chk("disc.ready", 64'(lu_ready), 1);
    chk("disc.stall", 64'(issue_stall), 0);
    // starvation preemption
    wb_valid = 1; wb_da = 4; wb_data = 32'h40;
    lu_valid = 1; lu_da = 9; lu_data = 32'h99;
    cyc();
    lu_valid = 0;
    chk_rf("stv.e0", 1, 4, 32'h40);
    chk("stv.hold0", 64'(wb_hold), 0);
    for (int i = 1; i <= 3; i++) begin
      wb_data = 32'h40 + 32'(i);
      cyc();
      chk_rf("stv.wb", 1, 4, 32'h40 + 32'(i));
      chk("stv.hold", 64'(wb_hold), (i == 3) ? 64'd1 : 64'd0);
    end
    cyc();
    chk_rf("stv.pre", 1, 9, 32'h99);
    chk("stv.release", 64'(wb_hold), 0);
    cyc();
    chk_rf("stv.wbheld", 1, 4, 32'h43);
    // fill the FIFO with writeback busy
    for (int i = 0; i < 4; i++) begin
      lu_valid = 1; lu_da = 5'(10 + i); lu_data = 32'hA0 + 32'(i);
      cyc();
      chk_rf("full.wb", 1, 4, 32'h43);
    end
    chk("full.ready", 64'(lu_ready), 0);
    chk("full.hold", 64'(wb_hold), 1);
    lu_da = 14; lu_data = 32'hA4;
    cyc();
    chk_rf("full.popA", 1, 10, 32'hA0);
    chk("full.ready3", 64'(lu_ready), 1);
    wb_valid = 0;
    cyc();
    lu_valid = 0;
    chk_rf("full.popB", 1, 11, 32'hA1);
    chk("full.occ3", 64'(lu_ready), 1);
    for (int i = 2; i <= 4; i++) begin
      cyc();
      chk_rf("full.order", 1, 5'(10 + i), 32'hA0 + 32'(i));
    end
    cyc();
    chk("full.drained", 64'(rf_rw), 0);
    // reset mid-burst with three entries queued and a pending destination
    wb_valid = 1; wb_da = 4; wb_data = 32'h77;
    iss_valid = 1; iss_long = 1; iss_da = 20;
    for (int i = 0; i < 3; i++) begin
      lu_valid = 1; lu_da = 5'(21 + i); lu_data = 32'hB0 + 32'(i);
      cyc();
      iss_valid = 0; iss_long = 0; iss_da = 0;
    end
    lu_valid = 0; chk_aa = 20;
    #1 chk("mid.pend", 64'(issue_stall), 1);
    rst_n = 0;
    #1;
    chk("mid.rw", 64'(rf_rw), 0);
    chk("mid.ready", 64'(lu_ready), 1);
    chk("mid.hold", 64'(wb_hold), 0);
    for (int r = 0; r < 32; r++) begin
      chk_aa = 5'(r); chk_ba = 5'(31 - r);
      #1 chk("mid.stall", 64'(issue_stall), 0);
    end
    chk_aa = 0; chk_ba = 0;
    wb_valid = 0;
    cyc();
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("post.rw", 64'(rf_rw), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
